// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU load/store port. Owns a byte-enabled
//   word RAM (2**ADDR_W x 32) and a four-register MMIO window (LED, CYCLE,
//   CMP, STATUS). Reads return the full 32-bit word one cycle after re_i;
//   byte/half extraction is done on the CPU side.
//
//   Ports
//     clk_i    : clock, rising edge
//     reset_i  : asynchronous, active-high reset
//     re_i     : read request this cycle
//     we_i     : byte-lane write enables, we_i[i] writes wdata_i[8i+7:8i]
//     addr_i   : word address (byte address >> 2)
//     wdata_i  : lane-steered write data
//     rdata_o  : read data, valid the cycle after re_i, held otherwise
//     leds_o   : LED register contents
//     irq_o    : timer interrupt, STATUS.pend & STATUS.en
//
//   Address map (word address)
//     addr[29]==0, addr[28:ADDR_W]==0 : RAM, index addr[ADDR_W-1:0]
//     addr[29]==1                     : IO, register addr[1:0] (aliased)
//     otherwise                       : unmapped, writes dropped, reads 0
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W    = 12,
    parameter int LED_W     = 8,
    parameter     INIT_FILE = ""
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             re_i,
    input  logic [3:0]       we_i,
    input  logic [29:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    output logic [LED_W-1:0] leds_o,
    output logic             irq_o
);

    localparam int RAM_WORDS = 2 ** ADDR_W;

    // Registered source select for rdata_o
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_RAM  = 2'd1;
    localparam logic [1:0] SEL_IO   = 2'd2;

    localparam logic [1:0] REG_LED    = 2'd0;
    localparam logic [1:0] REG_CYCLE  = 2'd1;
    localparam logic [1:0] REG_CMP    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic              ram_hit;
    logic              io_hit;
    logic [ADDR_W-1:0] ram_idx;
    logic [1:0]        reg_off;

    assign ram_hit = (addr_i[29:ADDR_W] == '0);
    assign io_hit  = addr_i[29];
    assign ram_idx = addr_i[ADDR_W-1:0];
    assign reg_off = addr_i[1:0];

    // ------------------------------------------------------------------
    // RAM: no reset so it maps onto block RAM. The read sits in the same
    // process as the write, so a same-edge read sees the pre-write word.
    // ram_q is only meaningful while sel_q selects RAM.
    // ------------------------------------------------------------------
    logic [31:0] mem [0:RAM_WORDS-1];
    logic [31:0] ram_q;

    always_ff @(posedge clk_i) begin
        if (ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem[ram_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i && ram_hit) begin
            ram_q <= mem[ram_idx];
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      cycle_q;
    logic [31:0]      cmp_q, cmp_d;
    logic             pend_q, pend_d;
    logic             en_q, en_d;
    logic [31:0]      io_q, io_rd_d;
    logic [1:0]       sel_q, sel_d;

    logic io_wr;
    logic status_clr;

    assign io_wr      = io_hit && (we_i != 4'b0000);
    assign status_clr = io_wr && (reg_off == REG_STATUS) && we_i[0] && wdata_i[0];

    always_comb begin
        led_d = led_q;
        cmp_d = cmp_q;
        en_d  = en_q;
        if (io_wr && reg_off == REG_LED) begin
            led_d = LED_W'(merge_bytes(32'(led_q), wdata_i, we_i));
        end
        if (io_wr && reg_off == REG_CMP) begin
            cmp_d = merge_bytes(cmp_q, wdata_i, we_i);
        end
        if (io_wr && reg_off == REG_STATUS && we_i[0]) begin
            en_d = wdata_i[1];
        end
        // Compare uses the post-write CMP so a CMP write equal to the
        // current count matches on that same edge; a match beats a clear.
        pend_d = (cycle_q == cmp_d) || (pend_q && !status_clr);
    end

    // Read mux uses pre-edge register values (read-first)
    always_comb begin
        io_rd_d = 32'h0;
        case (reg_off)
            REG_LED:    io_rd_d = 32'(led_q);
            REG_CYCLE:  io_rd_d = cycle_q;
            REG_CMP:    io_rd_d = cmp_q;
            REG_STATUS: io_rd_d = {30'h0, en_q, pend_q};
            default:    io_rd_d = 32'h0;
        endcase
    end

    always_comb begin
        sel_d = SEL_NONE;
        if (io_hit) begin
            sel_d = SEL_IO;
        end else if (ram_hit) begin
            sel_d = SEL_RAM;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            led_q   <= '0;
            cycle_q <= 32'h0;
            cmp_q   <= 32'hFFFF_FFFF;
            pend_q  <= 1'b0;
            en_q    <= 1'b0;
            io_q    <= 32'h0;
            sel_q   <= SEL_NONE;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_q + 32'd1;
            cmp_q   <= cmp_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            if (re_i) begin
                sel_q <= sel_d;
                io_q  <= io_rd_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset forces sel_q to NONE, so rdata_o reads 0 until the
    // next request regardless of what the RAM output register holds.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_o = 32'h0;
        case (sel_q)
            SEL_RAM: rdata_o = ram_q;
            SEL_IO:  rdata_o = io_q;
            default: rdata_o = 32'h0;
        endcase
    end

    assign leds_o = led_q;
    assign irq_o  = pend_q & en_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        re;
    logic [3:0]  we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    localparam logic [29:0] A_LED    = 30'h2000_0000;
    localparam logic [29:0] A_CYCLE  = 30'h2000_0001;
    localparam logic [29:0] A_CMP    = 30'h2000_0002;
    localparam logic [29:0] A_STATUS = 30'h2000_0003;

    mem_responder #(.ADDR_W(12), .LED_W(8), .INIT_FILE("")) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .re_i    (re),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .leds_o  (leds),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) edge_n++;
    endtask

    task automatic drive(input logic r, input logic [3:0] w, input logic [29:0] a, input logic [31:0] d);
        re    = r;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 30'h0, 32'h0);
    endtask

    initial begin
        // re, we, addr, wdata, chk_rd, exp_rd, exp_leds
        tbl[0]  = '{1'b0, 4'hF, 30'd5,         32'hDEADBEEF, 1'b1, 32'h0,        8'h00};
        tbl[1]  = '{1'b1, 4'h0, 30'd5,         32'h0,        1'b1, 32'hDEADBEEF, 8'h00};
        tbl[2]  = '{1'b0, 4'h0, 30'd5,         32'h0,        1'b1, 32'hDEADBEEF, 8'h00};
        tbl[3]  = '{1'b0, 4'h1, 30'd5,         32'h000000AA, 1'b1, 32'hDEADBEEF, 8'h00};
        tbl[4]  = '{1'b0, 4'h4, 30'd5,         32'h00BB0000, 1'b0, 32'h0,        8'h00};
        tbl[5]  = '{1'b1, 4'h0, 30'd5,         32'h0,        1'b1, 32'hDEBBBEAA, 8'h00};
        tbl[6]  = '{1'b0, 4'hF, 30'd7,         32'h0,        1'b0, 32'h0,        8'h00};
        tbl[7]  = '{1'b1, 4'hF, 30'd7,         32'h1,        1'b1, 32'h0,        8'h00};
        tbl[8]  = '{1'b1, 4'h0, 30'd7,         32'h0,        1'b1, 32'h1,        8'h00};
        tbl[9]  = '{1'b0, 4'h3, A_LED,         32'h00001234, 1'b1, 32'h1,        8'h34};
        tbl[10] = '{1'b1, 4'h0, A_LED,         32'h0,        1'b1, 32'h34,       8'h34};
        tbl[11] = '{1'b0, 4'hF, 30'd0,         32'h11111111, 1'b0, 32'h0,        8'h34};
        tbl[12] = '{1'b0, 4'hF, 30'h1000_0000, 32'hCAFEF00D, 1'b0, 32'h0,        8'h34};
        tbl[13] = '{1'b1, 4'h0, 30'h1000_0000, 32'h0,        1'b1, 32'h0,        8'h34};
        tbl[14] = '{1'b1, 4'h0, 30'd0,         32'h0,        1'b1, 32'h11111111, 8'h34};
        tbl[15] = '{1'b0, 4'hF, 30'h0000_1005, 32'h55555555, 1'b1, 32'h11111111, 8'h34};
        tbl[16] = '{1'b1, 4'h0, 30'd5,         32'h0,        1'b1, 32'hDEBBBEAA, 8'h34};
        tbl[17] = '{1'b1, 4'h0, 30'h2000_0004, 32'h0,        1'b1, 32'h34,       8'h34};
        tbl[18] = '{1'b0, 4'h2, A_LED,         32'h00005600, 1'b0, 32'h0,        8'h34};
        tbl[19] = '{1'b1, 4'h0, A_LED,         32'h0,        1'b1, 32'h34,       8'h34};
        tbl[20] = '{1'b0, 4'hF, A_CMP,         32'h12345678, 1'b0, 32'h0,        8'h34};
        tbl[21] = '{1'b1, 4'hF, A_CMP,         32'hA5A5A5A5, 1'b1, 32'h12345678, 8'h34};
        tbl[22] = '{1'b1, 4'h0, A_CMP,         32'h0,        1'b1, 32'hA5A5A5A5, 8'h34};

        // ---------------- reset state ----------------
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].re, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            tick();
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
            chk($sformatf("vec%0d_leds", i), {24'h0, leds}, {24'h0, tbl[i].exp_leds});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
        end
        idle();

        // ---------------- timer ----------------
        // Fresh reset so the counter value is known: after n edges CYCLE == n.
        reset = 1'b1;
        tick();
        chk("tmr_reset_leds", {24'h0, leds}, 32'h0);
        reset = 1'b0;
        edge_n = 0;
        drive(1'b0, 4'h1, A_STATUS, 32'h2);      // en=1
        tick();
        drive(1'b0, 4'hF, A_CMP, 32'd100);
        tick();
        drive(1'b0, 4'h1, A_LED, 32'h5A);
        tick();
        chk("tmr_leds", {24'h0, leds}, 32'h5A);
        idle();
        while (edge_n < 100) tick();
        chk("tmr_irq_before_match", {31'h0, irq}, 32'h0);
        tick();                                  // this edge sees CYCLE==100
        chk("tmr_irq_after_match", {31'h0, irq}, 32'h1);
        drive(1'b0, 4'h1, A_STATUS, 32'h3);      // clear pend, keep en
        tick();
        chk("tmr_irq_cleared", {31'h0, irq}, 32'h0);
        drive(1'b1, 4'h0, A_STATUS, 32'h0);
        tick();
        chk("tmr_status_rd", rdata, 32'h2);
        idle();
        repeat (5) tick();
        chk("tmr_no_reassert", {31'h0, irq}, 32'h0);
        drive(1'b0, 4'hF, A_CMP, edge_n);        // CMP := current CYCLE
        tick();
        chk("tmr_cmp_eq_cycle", {31'h0, irq}, 32'h1);
        drive(1'b0, 4'h1, A_STATUS, 32'h3);
        tick();
        chk("tmr_clear2", {31'h0, irq}, 32'h0);
        drive(1'b0, 4'hF, A_CMP, edge_n + 1);
        tick();
        chk("tmr_cmp_ahead", {31'h0, irq}, 32'h0);
        drive(1'b0, 4'h1, A_STATUS, 32'h3);      // clear on the matching edge
        tick();
        chk("tmr_set_wins", {31'h0, irq}, 32'h1);
        drive(1'b1, 4'h0, A_STATUS, 32'h0);
        tick();
        chk("tmr_status_rd2", rdata, 32'h3);

        // ---------------- async reset mid-operation ----------------
        drive(1'b1, 4'h0, 30'd5, 32'h0);
        tick();
        chk("mid_read", rdata, 32'hDEBBBEAA);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rdata", rdata, 32'h0);
        chk("async_leds", {24'h0, leds}, 32'h0);
        chk("async_irq", {31'h0, irq}, 32'h0);
        idle();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_rdata_hold0", rdata, 32'h0);
        drive(1'b1, 4'h0, A_CYCLE, 32'h0);
        tick();
        chk("post_rst_cycle1", rdata, 32'h1);
        tick();
        chk("post_rst_cycle2", rdata, 32'h2);
        drive(1'b1, 4'h0, 30'd5, 32'h0);
        tick();
        chk("post_rst_ram_intact", rdata, 32'hDEBBBEAA);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
